matrix_op_sequencer: RTL and testbench

Command sequencer in front of the `calc` matrix engine (32x32, 8-bit signed matrices in A/B/C memories). It accepts opcode commands from two requesters through round-robin arbitration and queues them in a small FIFO. It issues each command to the engine as `op` plus a one-cycle start pulse, holds `op` stable until the engine's sticky `finish` flag reports completion, then signals completion back to the requesters.

---
 rtl/matrix_op_pkg.sv | 26 ++
 rtl/op_fifo.sv | 72 +++++++
 rtl/matrix_op_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_matrix_op_sequencer.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_op_pkg.sv
// matrix_op_pkg
// Shared definitions for the matrix_op_sequencer block: engine opcodes,
// the sequencer FSM state encoding and the command-queue entry layout.
package matrix_op_pkg;

    localparam int OP_W    = 3;
    // Queue entry layout: {src, op}
    localparam int ENTRY_W = 4;

    localparam logic [OP_W-1:0] OP_ADD     = 3'b000;
    localparam logic [OP_W-1:0] OP_SUB_AB  = 3'b001;
    localparam logic [OP_W-1:0] OP_SUB_BA  = 3'b010;
    localparam logic [OP_W-1:0] OP_MUL     = 3'b011;
    localparam logic [OP_W-1:0] OP_TRANS_A = 3'b100;
    localparam logic [OP_W-1:0] OP_TRANS_B = 3'b101;
    localparam logic [OP_W-1:0] OP_TRACE_A = 3'b110;
    localparam logic [OP_W-1:0] OP_TRACE_B = 3'b111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        ARM   = 2'd2,
        RUN   = 2'd3
    } state_e;

endpackage

// File: rtl/op_fifo.sv
// op_fifo
// Synchronous FIFO holding queued sequencer commands. Read data is
// registered: the entry at the head is captured into rdata_o on pop and
// stays there until the next pop.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   push_i, wdata_i   write strobe and entry (ignored while full)
//   pop_i             read strobe (ignored while empty)
//   rdata_o           registered read data of the last popped entry
//   full_o, empty_o   occupancy flags
//   level_o           number of stored entries
module op_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0] level_q;
    logic [WIDTH-1:0] rdata_q;
    logic             do_push, do_pop;

    assign full_o  = (level_q == LVL_W'(DEPTH));
    assign empty_o = (level_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            rdata_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                rdata_q  <= mem_q[rd_ptr_q];
            end
            if (do_push && !do_pop) begin
                level_q <= level_q + LVL_W'(1);
            end else if (do_pop && !do_push) begin
                level_q <= level_q - LVL_W'(1);
            end
        end
    end

    assign rdata_o = rdata_q;
    assign level_o = level_q;

endmodule

// File: rtl/matrix_op_sequencer.sv
// matrix_op_sequencer
// Command sequencer in front of the calc matrix engine. Two requesters are
// round-robin arbitrated into a command queue; each queued command is issued
// to the engine as calc_op plus a one-cycle calc_start, held until the
// engine's sticky calc_finish reports completion, then reported on done.
// Optional watchdog: define MATRIX_OP_SEQ_TIMEOUT_EN to abort a command that
// stays in RUN for TIMEOUT_CYCLES cycles (sets sticky timeout_err).
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   reqN_valid/reqN_op/reqN_ready command handshake of requester N (N=0,1)
//   calc_op, calc_start           registered opcode and start pulse to engine
//   calc_finish                   sticky completion flag from the engine
//   done, done_op, done_src       one-cycle completion report
//   busy                          command in flight or queue not empty
//   fifo_level                    number of queued commands
//   timeout_err                   sticky watchdog flag
module matrix_op_sequencer
    import matrix_op_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 40000
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          req0_valid,
    input  logic [2:0]                    req0_op,
    output logic                          req0_ready,
    input  logic                          req1_valid,
    input  logic [2:0]                    req1_op,
    output logic                          req1_ready,
    output logic [2:0]                    calc_op,
    output logic                          calc_start,
    input  logic                          calc_finish,
    output logic                          done,
    output logic [2:0]                    done_op,
    output logic                          done_src,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          timeout_err
);

    logic               grant0, grant1;
    logic               push, pop, push_src;
    logic               fifo_full, fifo_empty;
    logic [ENTRY_W-1:0] push_entry, head_entry;
    logic               rr_q, rr_d;
    state_e             state_q, state_d;
    logic               start_q, start_d;
    logic               done_q, done_d;
    logic [OP_W-1:0]    done_op_q, done_op_d;
    logic               done_src_q, done_src_d;
    logic               wd_expired;

    // rr_q names the requester that wins when both are valid; it flips to the
    // other requester after every transfer.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (req0_valid && req1_valid) begin
            grant0 = ~rr_q;
            grant1 = rr_q;
        end else begin
            grant0 = req0_valid;
            grant1 = req1_valid;
        end
    end

    assign req0_ready = grant0 && !fifo_full;
    assign req1_ready = grant1 && !fifo_full;
    assign push       = (req0_valid && req0_ready) || (req1_valid && req1_ready);
    assign push_src   = grant1;
    assign push_entry = {push_src, push_src ? req1_op : req0_op};
    assign rr_d       = push ? ~push_src : rr_q;

    op_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .wdata_i (push_entry),
        .pop_i   (pop),
        .rdata_o (head_entry),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    // The FIFO's registered read data doubles as the calc_op/src register:
    // it loads on pop and holds until the next pop.
    always_comb begin
        state_d    = state_q;
        pop        = 1'b0;
        start_d    = 1'b0;
        done_d     = 1'b0;
        done_op_d  = done_op_q;
        done_src_d = done_src_q;
        case (state_q)
            IDLE: begin
                // The cycle that reports a completion is not used to pop, so
                // the next start follows a finish by three cycles.
                if (!fifo_empty && !done_q) begin
                    pop     = 1'b1;
                    start_d = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: state_d = ARM;
            // calc_finish still shows the previous command here.
            ARM:   state_d = RUN;
            RUN: begin
                if (calc_finish || wd_expired) begin
                    done_d     = 1'b1;
                    done_op_d  = head_entry[OP_W-1:0];
                    done_src_d = head_entry[ENTRY_W-1];
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rr_q       <= 1'b0;
            start_q    <= 1'b0;
            done_q     <= 1'b0;
            done_op_q  <= '0;
            done_src_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            start_q    <= start_d;
            done_q     <= done_d;
            done_op_q  <= done_op_d;
            done_src_q <= done_src_d;
        end
    end

`ifdef MATRIX_OP_SEQ_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] wd_cnt_q;
    logic            to_err_q;

    // Counter is zero on the first RUN cycle; it expires on the
    // TIMEOUT_CYCLES-th RUN cycle without a finish.
    assign wd_expired = (state_q == RUN) && !calc_finish &&
                        (wd_cnt_q == WD_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt_q <= '0;
            to_err_q <= 1'b0;
        end else begin
            if (state_q != RUN) begin
                wd_cnt_q <= '0;
            end else begin
                wd_cnt_q <= wd_cnt_q + WD_W'(1);
            end
            if (wd_expired) begin
                to_err_q <= 1'b1;
            end
        end
    end

    assign timeout_err = to_err_q;
`else
    assign wd_expired  = 1'b0;
    // Constant 0; TIMEOUT_CYCLES only matters with the watchdog built in.
    assign timeout_err = (TIMEOUT_CYCLES < 0);
`endif

    assign calc_op    = head_entry[OP_W-1:0];
    assign calc_start = start_q;
    assign done       = done_q;
    assign done_op    = done_op_q;
    assign done_src   = done_src_q;
    assign busy       = (state_q != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_matrix_op_sequencer.sv
module tb_matrix_op_sequencer;
    import matrix_op_pkg::*;

    localparam int DEPTH = 4;
    localparam int TO    = 100;

    typedef struct {
        int         src;
        logic [2:0] op;
        int         lat;
        logic [2:0] exp_op;
        int         exp_src;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic [2:0] req0_op = 3'd0, req1_op = 3'd0;
    logic       req0_ready, req1_ready;
    logic [2:0] calc_op;
    logic       calc_start;
    logic       calc_finish;
    logic       done;
    logic [2:0] done_op;
    logic       done_src;
    logic       busy;
    logic [2:0] fifo_level;
    logic       timeout_err;

    int nerr = 0;
    int nchk = 0;

    always #5 clk = ~clk;

    matrix_op_sequencer #(
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req0_valid  (req0_valid),
        .req0_op     (req0_op),
        .req0_ready  (req0_ready),
        .req1_valid  (req1_valid),
        .req1_op     (req1_op),
        .req1_ready  (req1_ready),
        .calc_op     (calc_op),
        .calc_start  (calc_start),
        .calc_finish (calc_finish),
        .done        (done),
        .done_op     (done_op),
        .done_src    (done_src),
        .busy        (busy),
        .fifo_level  (fifo_level),
        .timeout_err (timeout_err)
    );

    // Engine model: clears finish on the edge that samples start, raises it
    // eng_lat cycles later; eng_hang freezes it.
    logic eng_fin = 1'b0;
    logic eng_run = 1'b0;
    int   eng_cnt = 0;
    int   eng_lat = 5;
    logic eng_hang = 1'b0;
    assign calc_finish = eng_fin;

    always @(posedge clk) begin
        if (calc_start) begin
            eng_fin <= 1'b0;
            eng_cnt <= eng_lat;
            eng_run <= 1'b1;
        end else if (eng_run && !eng_hang) begin
            if (eng_cnt <= 1) begin
                eng_fin <= 1'b1;
                eng_run <= 1'b0;
            end else begin
                eng_cnt <= eng_cnt - 1;
            end
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Event recorder
    int start_cnt = 0, done_cnt = 0, fin_cnt = 0, grant_cnt = 0, op_glitch = 0;
    int start_arr [256];
    int start_op_arr [256];
    int done_arr [256];
    int done_op_arr [256];
    int done_src_arr [256];
    int done_busy_arr [256];
    int fin_arr [256];
    int grant_arr [256];
    logic       fin_prev = 1'b0;
    logic [2:0] op_prev = 3'd0;

    always @(negedge clk) begin
        if (calc_start) begin
            start_arr[start_cnt % 256]    <= cyc;
            start_op_arr[start_cnt % 256] <= int'(calc_op);
            start_cnt <= start_cnt + 1;
        end
        if (done) begin
            done_arr[done_cnt % 256]      <= cyc;
            done_op_arr[done_cnt % 256]   <= int'(done_op);
            done_src_arr[done_cnt % 256]  <= int'(done_src);
            done_busy_arr[done_cnt % 256] <= int'(busy);
            done_cnt <= done_cnt + 1;
        end
        if (eng_fin && !fin_prev) begin
            fin_arr[fin_cnt % 256] <= cyc;
            fin_cnt <= fin_cnt + 1;
        end
        fin_prev <= eng_fin;
        if (rst_n && (calc_op != op_prev) && !calc_start) op_glitch <= op_glitch + 1;
        op_prev <= calc_op;
        if (rst_n && req0_valid && req0_ready) begin
            grant_arr[grant_cnt % 256] <= 0;
            grant_cnt <= grant_cnt + 1;
        end else if (rst_n && req1_valid && req1_ready) begin
            grant_arr[grant_cnt % 256] <= 1;
            grant_cnt <= grant_cnt + 1;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_cmd(input int s, input logic [2:0] op, output int hs);
        int k;
        k = 0;
        @(negedge clk);
        if (s == 0) begin req0_valid = 1'b1; req0_op = op; end
        else        begin req1_valid = 1'b1; req1_op = op; end
        #1;
        while (!((s == 0) ? req0_ready : req1_ready) && k < 200) begin
            @(negedge clk); #1; k++;
        end
        hs = cyc;
        chk("push_ready", int'(k < 200), 1);
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic wait_starts(input int target, input int budget, input string name);
        int k;
        k = 0;
        while (start_cnt < target && k < budget) begin @(negedge clk); #1; k++; end
        chk(name, int'(start_cnt >= target), 1);
    endtask

    task automatic wait_dones(input int target, input int budget, input string name);
        int k;
        k = 0;
        while (done_cnt < target && k < budget) begin @(negedge clk); #1; k++; end
        chk(name, int'(done_cnt >= target), 1);
    endtask

    task automatic run_vec(input vec_t v);
        int hs, sc0, dc0;
        sc0 = start_cnt;
        dc0 = done_cnt;
        eng_lat = v.lat;
        push_cmd(v.src, v.op, hs);
        wait_starts(sc0 + 1, 10, "vec_start_seen");
        chk("vec_start_latency", start_arr[sc0] - hs, 2);
        chk("vec_start_op", start_op_arr[sc0], int'(v.exp_op));
        wait_dones(dc0 + 1, v.lat + 50, "vec_done_seen");
        chk("vec_done_after_finish", done_arr[dc0] - fin_arr[(fin_cnt - 1) % 256], 1);
        chk("vec_done_op", done_op_arr[dc0], int'(v.exp_op));
        chk("vec_done_src", done_src_arr[dc0], v.exp_src);
        repeat (5) @(negedge clk);
        #1;
        chk("vec_single_done", done_cnt - dc0, 1);
        chk("vec_idle_busy", int'(busy), 0);
        chk("vec_calc_op_held", int'(calc_op), int'(v.exp_op));
    endtask

    initial begin
        #500000;
        $display("FAIL global_time_limit: simulation did not complete");
        $fatal(1, "time limit");
    end

    initial begin
        vec_t vecs [8];
        int hs, sc0, dc0, fc0, gc0, e;

        vecs[0] = '{src: 0, op: OP_ADD,     lat: 1025, exp_op: OP_ADD,     exp_src: 0};
        vecs[1] = '{src: 1, op: OP_SUB_AB,  lat: 7,    exp_op: OP_SUB_AB,  exp_src: 1};
        vecs[2] = '{src: 0, op: OP_SUB_BA,  lat: 12,   exp_op: OP_SUB_BA,  exp_src: 0};
        vecs[3] = '{src: 1, op: OP_MUL,     lat: 30,   exp_op: OP_MUL,     exp_src: 1};
        vecs[4] = '{src: 0, op: OP_TRANS_A, lat: 5,    exp_op: OP_TRANS_A, exp_src: 0};
        vecs[5] = '{src: 1, op: OP_TRANS_B, lat: 9,    exp_op: OP_TRANS_B, exp_src: 1};
        vecs[6] = '{src: 0, op: OP_TRACE_A, lat: 3,    exp_op: OP_TRACE_A, exp_src: 0};
        vecs[7] = '{src: 1, op: OP_TRACE_B, lat: 1,    exp_op: OP_TRACE_B, exp_src: 1};

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        chk("rst_outputs", int'({calc_op, calc_start, done, done_op, done_src, busy, timeout_err}), 0);
        chk("rst_level", int'(fifo_level), 0);
        chk("rst_ready", int'({req0_ready, req1_ready}), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Contention: both requesters valid every cycle
        sc0 = start_cnt; dc0 = done_cnt; gc0 = grant_cnt;
        eng_lat = 20;
        @(negedge clk);
        req0_op = OP_MUL; req1_op = OP_TRANS_A;
        req0_valid = 1'b1; req1_valid = 1'b1;
        repeat (6) @(negedge clk);
        #1;
        chk("cont_level_full", int'(fifo_level), 4);
        chk("cont_ready0_low", int'(req0_ready), 0);
        chk("cont_ready1_low", int'(req1_ready), 0);
        chk("cont_transfers", grant_cnt - gc0, 5);
        req0_valid = 1'b0; req1_valid = 1'b0;
        wait_dones(dc0 + 5, 1000, "cont_all_done");
        for (int i = 0; i < 5; i++) begin
            e = i % 2;
            chk("cont_grant_order", grant_arr[gc0 + i], e);
            chk("cont_done_src", done_src_arr[dc0 + i], e);
            chk("cont_done_op", done_op_arr[dc0 + i], (e == 1) ? int'(OP_TRANS_A) : int'(OP_MUL));
        end
        chk("cont_starts", start_cnt - sc0, 5);

        // Single commands, all opcodes, stale finish between them
        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // Back-to-back: four queued commands
        sc0 = start_cnt; dc0 = done_cnt; fc0 = fin_cnt;
        eng_lat = 10;
        push_cmd(0, OP_ADD, hs);
        push_cmd(1, OP_SUB_AB, hs);
        push_cmd(0, OP_MUL, hs);
        push_cmd(1, OP_TRACE_B, hs);
        wait_dones(dc0 + 4, 400, "b2b_all_done");
        for (int i = 1; i < 4; i++)
            chk("b2b_start_after_finish", start_arr[sc0 + i] - fin_arr[fc0 + i - 1], 3);
        for (int i = 0; i < 4; i++)
            chk("b2b_busy_at_done", done_busy_arr[dc0 + i], (i < 3) ? 1 : 0);
        chk("b2b_order_0", done_op_arr[dc0], int'(OP_ADD));
        chk("b2b_order_3", done_op_arr[dc0 + 3], int'(OP_TRACE_B));
        repeat (3) @(negedge clk);

        // Watchdog
`ifdef MATRIX_OP_SEQ_TIMEOUT_EN
        sc0 = start_cnt; dc0 = done_cnt;
        eng_hang = 1'b1; eng_lat = 8;
        push_cmd(0, OP_TRACE_A, hs);
        push_cmd(1, OP_ADD, hs);
        wait_dones(dc0 + 1, 400, "wd_timeout_done");
        chk("wd_timeout_latency", done_arr[dc0] - start_arr[sc0], TO + 2);
        chk("wd_timeout_err", int'(timeout_err), 1);
        chk("wd_done_op", done_op_arr[dc0], int'(OP_TRACE_A));
        chk("wd_done_src", done_src_arr[dc0], 0);
        eng_hang = 1'b0;
        wait_dones(dc0 + 2, 100, "wd_next_done");
        chk("wd_next_start", start_arr[sc0 + 1] - done_arr[dc0], 2);
        chk("wd_next_op", done_op_arr[dc0 + 1], int'(OP_ADD));
        chk("wd_next_src", done_src_arr[dc0 + 1], 1);
        chk("wd_err_sticky", int'(timeout_err), 1);
`else
        dc0 = done_cnt;
        eng_hang = 1'b1; eng_lat = 8;
        push_cmd(0, OP_TRANS_B, hs);
        repeat (300) @(negedge clk);
        #1;
        chk("nowd_no_done", done_cnt - dc0, 0);
        chk("nowd_busy", int'(busy), 1);
        chk("nowd_err_zero", int'(timeout_err), 0);
        eng_hang = 1'b0;
        wait_dones(dc0 + 1, 50, "nowd_done_after_finish");
        chk("nowd_done_op", done_op_arr[dc0], int'(OP_TRANS_B));
`endif
        repeat (3) @(negedge clk);

        // Reset mid-RUN with three entries queued
        eng_lat = 200;
        push_cmd(0, OP_MUL, hs);
        push_cmd(1, OP_SUB_BA, hs);
        push_cmd(0, OP_TRANS_A, hs);
        push_cmd(1, OP_TRACE_A, hs);
        #1;
        chk("rstrun_level_before", int'(fifo_level), 3);
        chk("rstrun_busy_before", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("rstrun_outputs", int'({calc_op, calc_start, done, done_op, done_src, busy, timeout_err}), 0);
        chk("rstrun_level", int'(fifo_level), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        sc0 = start_cnt;
        repeat (30) @(negedge clk);
        #1;
        chk("rstrun_no_start", start_cnt - sc0, 0);
        run_vec('{src: 1, op: OP_MUL, lat: 6, exp_op: OP_MUL, exp_src: 1});

        chk("calc_op_stable", op_glitch, 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
